fifo_stream_reader: RTL

- Read-side master for the team's synchronous FIFO pop interface (rd_en / rdata / empty).
- The FIFO's rdata is registered one cycle after an accepted rd_en; this block hides that latency.
- Presents the FIFO contents as a valid/ready stream at full throughput (one beat per cycle), with out_last framing every BURST_LEN beats.
- Sits between a sync FIFO and any stream consumer (packetizer, serializer).

---
 rtl/fifo_pkg.sv | 12 +
 rtl/stream_skid_buf.sv | 75 +++++++
 rtl/fifo_stream_reader.sv | 69 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapters.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 8;

  // One stream beat as seen by a consumer: payload plus frame marker.
  typedef struct packed {
    logic [FIFO_DATA_W-1:0] data;
    logic                   last;
  } stream_beat_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer: words pushed at the tail, presented from the head
// as a registered valid/data pair until the consumer pops them.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_push,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             pop;

  always_comb begin
    pop    = valid_q && out_ready;
    mem_d  = mem_q;
    if (in_push) begin
      mem_d[tail_q] = in_data;
    end
    head_d  = head_q ^ pop;
    tail_d  = tail_q ^ in_push;
    occ_d   = occ_q + {1'b0, in_push} - {1'b0, pop};
    // Outputs are registered from the post-update view so a word captured
    // into an empty buffer is visible on the very next cycle.
    valid_d = (occ_d != 2'd0);
    data_d  = mem_d[head_d];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO ahead of demand and re-presents its words as a
// full-rate valid/ready stream framed every BURST_LEN beats.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FIFO_DATA_W,
  parameter  int unsigned BURST_LEN  = 4,
  localparam int unsigned CNT_W      = $clog2(BURST_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  logic             pend_q, pend_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]       occ;
  logic [2:0]       inflight;
  logic             pop;

  stream_skid_buf #(
    .WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_push  (pend_q),
    .in_data  (fifo_rdata),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .occ      (occ)
  );

  always_comb begin
    pop = out_valid && out_ready;
    // Count the word still in flight from the FIFO and credit a same-cycle
    // pop, so the buffer never overfills yet never starves the stream.
    inflight   = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
    fifo_rd_en = !fifo_empty && (inflight < 3'd2);
    pend_d     = fifo_rd_en;
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + CNT_W'(1);
    end
    out_last = out_valid && (beat_cnt_q == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;

endmodule
